ext_pipe: RTL and testbench
===========================

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IMM_W, default 16, width of the incoming immediate.
REQ-002 Parameter OUT_W, default 32, width of the extended result; OUT_W SHALL be >= IMM_W+2.
REQ-003 Parameter DEPTH, default 2, result buffer entries; a power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-high.
REQ-006 in_valid  input  1  producer presents a request.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_imm  input  IMM_W  immediate field.
REQ-009 in_mode  input  2  extension mode: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH.
REQ-010 out_valid  output  1  buffer head holds a result.
REQ-011 out_ready  input  1  consumer accepts the head this cycle.
REQ-012 out_ext  output  OUT_W  extended result at buffer head.
REQ-013 out_err  output  1  head entry used an unsupported mode.

Function
REQ-014 Accept on clk edge where in_valid && in_ready; release on edge where out_valid && out_ready.
REQ-015 in_ready SHALL equal (count < DEPTH), from registered count only; no combinational path from out_ready.
REQ-016 SIGN: upper OUT_W-IMM_W bits = in_imm[IMM_W-1]; ZERO: upper bits = 0.
REQ-017 UPPER: in_imm placed in bits [OUT_W-1 : OUT_W-IMM_W], lower bits 0.
REQ-018 BRANCH: sign-extended value shifted left by 2, bits above OUT_W-1 discarded.
REQ-019 Result computed combinationally on input and written to buffer at accept; latency exactly 1 cycle (out_valid high the cycle after accept into empty buffer).
REQ-020 Buffer is FIFO order; read/write pointers wrap modulo DEPTH.
REQ-021 Full (count == DEPTH): in_ready low; in_valid ignored; no overwrite.
REQ-022 Empty: out_valid low; out_ext and out_err driven 0.
REQ-023 Simultaneous accept and release: count unchanged, both pointers advance.
REQ-024 Inputs are ignored when in_ready is low; out_ext/out_err SHALL hold stable while out_valid && !out_ready.

Reset
REQ-025 While reset high: count, pointers, all buffer entries = 0; out_valid 0, out_ext 0, out_err 0, in_ready 0.
REQ-026 First cycle after reset release: in_ready 1.
REQ-027 Reset asserted mid-operation discards all buffered results immediately; none appear afterwards.

Configuration
REQ-028 Macro EXT_BRANCH_MODE_EN: defined -> mode 3 performs BRANCH per REQ-018, out_err 0.
REQ-029 Undefined -> mode 3 produces SIGN result and sets out_err 1 for that entry; modes 0-2 unaffected.

Structure
REQ-030 Package ext_pkg holds mode constants (EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH) and the 2-bit mode width.
REQ-031 Buffer implemented as sub-module ext_fifo (parametrised width, DEPTH); extension logic stays in ext_pipe.

Verification
REQ-032 Defaults, mode 0, in_imm 16'h8001, out_ready 1 -> next cycle out_ext 32'hFFFF8001, out_valid 1.
REQ-033 Mode 1, in_imm 16'h8001 -> 32'h00008001; mode 2, in_imm 16'h1234 -> 32'h12340000.
REQ-034 Mode 3, in_imm 16'hFFFF: with macro -> 32'hFFFFFFFC, out_err 0; without -> 32'hFFFFFFFF, out_err 1.
REQ-035 out_ready 0, push 3 requests -> first two accepted, in_ready 0 after second, third held; release one -> third accepted; order preserved 1,2,3.
REQ-036 Full buffer, out_ready 1 and in_valid 1 every cycle for 10 cycles -> one result per cycle, pointers wrap, no loss or duplication.
REQ-037 Reset pulse with 2 entries buffered -> out_valid 0 during reset, in_ready 1 after release, no stale result emitted.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the immediate-extension pipeline.
//   MODE_W     - width of the extension-mode field
//   ext_mode_e - extension modes: EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH
package ext_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_e;

endpackage

// File: rtl/ext_fifo.sv
// ext_fifo: small FIFO result buffer with registered occupancy count.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   WIDTH entry to write
//   has_space  out  count < DEPTH
//   pop        in   release the head entry this cycle (ignored when empty)
//   has_data   out  count != 0
//   head       out  head entry, all zeros when empty
module ext_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             has_space,
    input  logic             pop,
    output logic             has_data,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign has_space = (count < FULL_CNT);
    assign has_data  = (count != '0);
    assign do_push   = push && has_space;
    assign do_pop    = pop && has_data;
    assign head      = has_data ? mem[rd_ptr] : '0;

    // Pointers are exactly log2(DEPTH) bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            // NOTE: non-blocking assignments make every register in this block
            // update from pre-edge values, so order of statements does not matter.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage is reset here because entries must read as zero after
    // reset; a plain RAM without reset would need that guarantee elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: immediate-extension unit with a DEPTH-entry result buffer.
// The extension is computed combinationally from the request and stored at
// accept, so a result reaches the output one cycle after it is accepted.
// Parameters: IMM_W (immediate width), OUT_W (result width, >= IMM_W+2),
//             DEPTH (buffer entries, power of two, >= 2).
// Configuration macro: EXT_BRANCH_MODE_EN
//   defined   - mode 3 is BRANCH (sign-extend, shift left by 2), out_err 0
//   undefined - mode 3 falls back to SIGN and flags out_err for that entry
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   in_valid   in   request present
//   in_ready   out  request can be accepted (buffer not full, not in reset)
//   in_imm     in   IMM_W immediate
//   in_mode    in   2-bit mode: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH
//   out_valid  out  buffer head holds a result
//   out_ready  in   consumer takes the head this cycle
//   out_ext    out  OUT_W extended result at head, 0 when empty
//   out_err    out  head used an unsupported mode, 0 when empty
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_ext,
    output logic             out_err
);

    localparam int EXT_W = OUT_W - IMM_W;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] ext_val;
    logic             ext_err;
    logic             has_space;
    logic             accept;

    assign sign_ext  = {{EXT_W{in_imm[IMM_W-1]}}, in_imm};
    assign zero_ext  = {{EXT_W{1'b0}}, in_imm};
    assign upper_ext = {in_imm, {EXT_W{1'b0}}};

`ifdef EXT_BRANCH_MODE_EN
    logic [OUT_W-1:0] branch_ext;
    // Bits shifted past OUT_W-1 are simply dropped.
    assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};
`endif

    // NOTE: defaults assigned first so every path writes both outputs and no
    // latch is inferred.
    always_comb begin
        ext_val = sign_ext;
        ext_err = 1'b0;
        case (ext_mode_e'(in_mode))
            EXT_SIGN:  ext_val = sign_ext;
            EXT_ZERO:  ext_val = zero_ext;
            EXT_UPPER: ext_val = upper_ext;
            EXT_BRANCH: begin
`ifdef EXT_BRANCH_MODE_EN
                ext_val = branch_ext;
`else
                ext_val = sign_ext;
                ext_err = 1'b1;
`endif
            end
        endcase
    end

    // Ready depends only on the registered count (and reset), never on out_ready.
    assign in_ready = has_space && !reset;
    assign accept   = in_valid && in_ready;

    ext_fifo #(
        .WIDTH(OUT_W + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data ({ext_err, ext_val}),
        .has_space (has_space),
        .pop       (out_ready),
        .has_data  (out_valid),
        .head      ({out_err, out_ext})
    );

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe with default parameters.
// Accepted requests are logged into an expected-result queue from a
// reference model; a monitor pops and compares each released result.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ext;
    logic        out_err;

    typedef struct packed {
        logic        err;
        logic [31:0] ext;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    bit          mon_en  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_head  = '0;

    ext_pipe #(.IMM_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ext   (out_ext),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: value of the immediate as a signed number, then arithmetic per mode.
    function automatic exp_t model(input logic [15:0] imm, input logic [1:0] mode);
        exp_t        e;
        logic [31:0] s;
        s = imm[15] ? (32'(imm) - 32'h0001_0000) : 32'(imm);
        e.err = 1'b0;
        case (mode)
            2'd0: e.ext = s;
            2'd1: e.ext = 32'(imm);
            2'd2: e.ext = 32'(imm) * 32'd65536;
            default: begin
`ifdef EXT_BRANCH_MODE_EN
                e.ext = s * 32'd4;
`else
                e.ext = s;
                e.err = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Request logger: every handshake about to complete is recorded.
    initial forever begin
        @(negedge clk);
        if (mon_en && !reset && in_valid && in_ready)
            sb.push_back(model(in_imm, in_mode));
    end

    // Monitor: compares released results and hold stability under backpressure.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (mon_en && !reset) begin
            if (prev_stall)
                check("hold_stable", {out_valid, out_err, out_ext}, {1'b1, prev_head});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_output: got %h, expected no output", {out_err, out_ext});
                end else begin
                    e = sb.pop_front();
                    check("scoreboard", {out_err, out_ext}, e);
                end
                n_out++;
            end
        end
        prev_stall = mon_en && !reset && out_valid && !out_ready;
        prev_head  = {out_err, out_ext};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
    endtask

    task automatic drain(input int cycles);
        drive(1'b0, 16'h0, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) step();
    endtask

    logic [15:0] dir_imm [4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
    logic [32:0] dir_exp [4];

    initial begin
        int base;
        dir_exp[0] = {1'b0, 32'hFFFF_8001};
        dir_exp[1] = {1'b0, 32'h0000_8001};
        dir_exp[2] = {1'b0, 32'h1234_0000};
`ifdef EXT_BRANCH_MODE_EN
        dir_exp[3] = {1'b0, 32'hFFFF_FFFC};
`else
        dir_exp[3] = {1'b1, 32'hFFFF_FFFF};
`endif

        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 2'd0);
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_bus", {out_err, out_ext}, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        check("empty_out_bus", {out_valid, out_err, out_ext}, 0);
        mon_en = 1'b1;

        // One request per mode into an empty buffer: result exactly one cycle later.
        for (int m = 0; m < 4; m++) begin
            step();
            out_ready = 1'b1;
            drive(1'b1, dir_imm[m], 2'(m));
            @(negedge clk);
            check("pre_accept_out_valid", out_valid, 0);
            step();
            drive(1'b0, 16'h0, 2'd0);
            @(negedge clk);
            check("latency1_result", {out_valid, out_err, out_ext}, {1'b1, dir_exp[m]});
            drain(2);
        end

        // Backpressure: third request is held until a slot frees; order kept.
        base = n_out;
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 2'd1);
        step();
        drive(1'b1, 16'h0002, 2'd1);
        step();
        drive(1'b1, 16'h0003, 2'd1);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        step();
        @(negedge clk);
        check("full_still_held", in_ready, 0);
        check("full_head", out_ext, 32'h0000_0001);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("freed_in_ready", in_ready, 1);
        step();
        drain(4);
        check("backpressure_count", n_out - base, 3);

        // Full buffer streaming: one result per cycle with pointers wrapping.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'($urandom), 2'($urandom));
            step();
        end
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'($urandom), 2'($urandom));
            @(negedge clk);
            check("stream_valid", out_valid, 1);
            step();
        end
        check("stream_count", n_out - base, 10);
        drain(4);

        // Reset with two entries buffered: everything discarded.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'($urandom), 2'($urandom));
            step();
        end
        drive(1'b0, 16'h0, 2'd0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_out_bus", {out_err, out_ext}, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_valid", out_valid, 0);
            step();
        end
        check("no_stale_count", n_out - base, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 16'($urandom), 2'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        drain(6);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
